mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single synchronous word-wide SRAM port between two requesters:
//  port 0 = instruction fetch, port 1 = load/store unit.
//  Arbitrates round-robin and converts byte/half/word requests into a word
//  address, byte enables and lane-replicated write data.
//  Aligns and extends read data, and reports misaligned/illegal sizes as errors.
//  Sits between the core pipeline and the SRAM macro.
// PARAMETERS
//  XLEN  32  address width; SRAM word address is XLEN-2 bits
// PORTS
//  clk          in   1       clock, all state on posedge
//  rstn         in   1       synchronous active-low reset
//  pN_valid     in   1       port N (N=0,1) request valid
//  pN_ready     out  1       port N request accepted this cycle
//  pN_write     in   1       1=store, 0=load
//  pN_size      in   2       00 byte, 01 half, 10 word, 11 illegal
//  pN_unsigned  in   1       zero-extend load (byte/half), else sign-extend
//  pN_addr      in   XLEN    byte address
//  pN_wdata     in   32      store data, right-justified
//  pN_rsp_valid out  1       one-cycle response strobe
//  pN_rsp_rdata out  32      aligned/extended load data (0 for stores/errors)
//  pN_rsp_err   out  1       misaligned or illegal size; qualified by rsp_valid
//  sram_en      out  1       SRAM access this cycle
//  sram_we      out  1       write when sram_en
//  sram_addr    out  XLEN-2  word address = addr[XLEN-1:2]
//  sram_be      out  4       byte-lane enables, bit i = bits [8i+7:8i]
//  sram_wdata   out  32      lane-replicated write data
//  sram_rdata   in   32      read data, valid the cycle after a read enable
// BEHAVIOUR
//  - Reset (clk edge with rstn=0): state=IDLE, last_grant=1, all outputs 0,
//    captured request cleared. Mid-transaction reset aborts; no response is
//    issued and sram_en is 0 from the cycle after the reset edge.
//  - FSM IDLE -> ISSUE -> RESP -> IDLE; IDLE -> RESP directly on error.
//  - IDLE: pick winner among valid ports. Both valid -> port != last_grant.
//    Winner's pN_ready=1 combinationally in that cycle. Loser's ready=0.
//    pN_ready is 0 in ISSUE/RESP. On accept, register port id, write, size,
//    unsigned, addr, wdata; last_grant<=winner.
//  - Error check at accept: size=11, or half with addr[0]=1, or word with
//    addr[1:0]!=0 -> go to RESP with err=1; SRAM never enabled.
//  - ISSUE: sram_en=1, sram_we=write, sram_addr, sram_be, sram_wdata from
//    registered request. be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0};
//    word 4'b1111. wdata: byte {4{wd[7:0]}}, half {2{wd[15:0]}}, word wd.
//    sram_en is 0 in all other states.
//  - RESP: pN_rsp_valid=1 for exactly one cycle on granted port only.
//    Load data: byte = sram_rdata lane addr[1:0]; half = lane pair addr[1];
//    word = full. Extend per unsigned to 32 bits.
//    Stores respond with rdata=0, err=0.
//  - Latency: accept at cycle T -> SRAM access at T+1 -> response at T+2
//    (error: response at T+1). New accept earliest in the cycle after RESP.
//    Max one transaction in flight; throughput 1 per 3 cycles.
//  - Requester must hold valid and request fields until ready; changes while
//    not ready are allowed (not latched).
//  - rsp outputs of the idle port are 0; rsp_rdata/err are 0 outside RESP.
// TESTING
//  1 Reset then p0 load word addr 0x100, SRAM word 0x40 = 0xDEADBEEF
//    -> p0_ready T0, sram_en/addr 0x40/be 1111 T1, p0_rsp_rdata 0xDEADBEEF T2.
//  2 p1 store byte 0xA5 to addr 0x203 -> be 1000, wdata 0xA5A5A5A5, we=1;
//    load byte signed from 0x203 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
//  3 Both ports valid continuously -> grants alternate 0,1,0,1 (port 0 first
//    after reset); every response arrives on the correct port only.
//  4 p1 load half at 0x102, word 0x8877_6655 -> 0x00008877 unsigned;
//    half at 0x101 -> err=1 at T+1, sram_en never asserted.
//  5 Assert rstn=0 in ISSUE cycle -> no rsp_valid, FSM IDLE, next request OK.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one word-wide synchronous SRAM port between
// instruction fetch (port 0) and load/store (port 1), with sub-word handling.
module mem_port_arbiter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            p0_valid,
  output logic            p0_ready,
  input  logic            p0_write,
  input  logic [1:0]      p0_size,
  input  logic            p0_unsigned,
  input  logic [XLEN-1:0] p0_addr,
  input  logic [31:0]     p0_wdata,
  output logic            p0_rsp_valid,
  output logic [31:0]     p0_rsp_rdata,
  output logic            p0_rsp_err,
  input  logic            p1_valid,
  output logic            p1_ready,
  input  logic            p1_write,
  input  logic [1:0]      p1_size,
  input  logic            p1_unsigned,
  input  logic [XLEN-1:0] p1_addr,
  input  logic [31:0]     p1_wdata,
  output logic            p1_rsp_valid,
  output logic [31:0]     p1_rsp_rdata,
  output logic            p1_rsp_err,
  output logic            sram_en,
  output logic            sram_we,
  output logic [XLEN-3:0] sram_addr,
  output logic [3:0]      sram_be,
  output logic [31:0]     sram_wdata,
  input  logic [31:0]     sram_rdata
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            last_grant;
  logic            accept;
  logic            grant;
  logic            sel_write, sel_unsigned, sel_err;
  logic [1:0]      sel_size;
  logic [XLEN-1:0] sel_addr;
  logic [31:0]     sel_wdata;

  logic            req_port, req_write, req_unsigned, req_err;
  logic [1:0]      req_size;
  logic [XLEN-1:0] req_addr;
  logic [31:0]     req_wdata;

  logic [3:0]      be_c;
  logic [31:0]     wdata_c;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_data;
  logic [31:0]     rsp_data;

  // Winner: the port that did not win last time when both ask.
  always_comb begin
    grant = 1'b0;
    if (p0_valid && p1_valid) grant = ~last_grant;
    else if (p1_valid)        grant = 1'b1;
  end

  assign sel_write    = grant ? p1_write    : p0_write;
  assign sel_size     = grant ? p1_size     : p0_size;
  assign sel_unsigned = grant ? p1_unsigned : p0_unsigned;
  assign sel_addr     = grant ? p1_addr     : p0_addr;
  assign sel_wdata    = grant ? p1_wdata    : p0_wdata;
  assign sel_err      = (sel_size == SZ_ILL)
                      || ((sel_size == SZ_HALF) && sel_addr[0])
                      || ((sel_size == SZ_WORD) && (sel_addr[1:0] != 2'b00));

  // Byte enables and lane-replicated store data for the captured request.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        be_c    = 4'(4'b0001 << req_addr[1:0]);
        wdata_c = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane selection and extension.
  always_comb begin
    case (req_addr[1:0])
      2'd1:    ld_byte = sram_rdata[15:8];
      2'd2:    ld_byte = sram_rdata[23:16];
      2'd3:    ld_byte = sram_rdata[31:24];
      default: ld_byte = sram_rdata[7:0];
    endcase
    ld_half = req_addr[1] ? sram_rdata[31:16] : sram_rdata[15:0];
    case (req_size)
      SZ_BYTE: ld_data = {{24{~req_unsigned & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{~req_unsigned & ld_half[15]}}, ld_half};
      default: ld_data = sram_rdata;
    endcase
    rsp_data = (req_err || req_write) ? 32'h0 : ld_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    p0_ready     = 1'b0;
    p1_ready     = 1'b0;
    sram_en      = 1'b0;
    sram_we      = 1'b0;
    sram_addr    = '0;
    sram_be      = 4'b0000;
    sram_wdata   = 32'h0;
    p0_rsp_valid = 1'b0;
    p0_rsp_rdata = 32'h0;
    p0_rsp_err   = 1'b0;
    p1_rsp_valid = 1'b0;
    p1_rsp_rdata = 32'h0;
    p1_rsp_err   = 1'b0;
    case (state)
      S_IDLE: begin
        if (p0_valid || p1_valid) begin
          accept    = 1'b1;
          p0_ready  = ~grant;
          p1_ready  = grant;
          // Faulty requests skip the SRAM entirely.
          state_nxt = sel_err ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        sram_en    = 1'b1;
        sram_we    = req_write;
        sram_addr  = req_addr[XLEN-1:2];
        sram_be    = be_c;
        sram_wdata = wdata_c;
        state_nxt  = S_RESP;
      end
      S_RESP: begin
        state_nxt = S_IDLE;
        if (req_port) begin
          p1_rsp_valid = 1'b1;
          p1_rsp_rdata = rsp_data;
          p1_rsp_err   = req_err;
        end else begin
          p0_rsp_valid = 1'b1;
          p0_rsp_rdata = rsp_data;
          p0_rsp_err   = req_err;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request capture on accept.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_grant   <= 1'b1;
      req_port     <= 1'b0;
      req_write    <= 1'b0;
      req_size     <= 2'b00;
      req_unsigned <= 1'b0;
      req_err      <= 1'b0;
      req_addr     <= '0;
      req_wdata    <= 32'h0;
    end else if (accept) begin
      last_grant   <= grant;
      req_port     <= grant;
      req_write    <= sel_write;
      req_size     <= sel_size;
      req_unsigned <= sel_unsigned;
      req_err      <= sel_err;
      req_addr     <= sel_addr;
      req_wdata    <= sel_wdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural SRAM.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        p0_valid, p0_ready, p0_write, p0_unsigned;
  logic [1:0]  p0_size;
  logic [31:0] p0_addr, p0_wdata, p0_rsp_rdata;
  logic        p0_rsp_valid, p0_rsp_err;
  logic        p1_valid, p1_ready, p1_write, p1_unsigned;
  logic [1:0]  p1_size;
  logic [31:0] p1_addr, p1_wdata, p1_rsp_rdata;
  logic        p1_rsp_valid, p1_rsp_err;
  logic        sram_en, sram_we;
  logic [29:0] sram_addr;
  logic [3:0]  sram_be;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  logic [31:0] mem [0:1023];

  int n_tests = 0;
  int n_fail  = 0;

  int          o_wait;
  logic        o_ready;
  logic        o_en1, o_we1, o_rv1, o_err1, o_orv1, o_en2, o_rv2, o_err2, o_orv2;
  logic [29:0] o_addr1;
  logic [3:0]  o_be1;
  logic [31:0] o_wd1, o_rd1, o_rd2;

  mem_port_arbiter #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_write(p0_write),
    .p0_size(p0_size), .p0_unsigned(p0_unsigned), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_write(p1_write),
    .p1_size(p1_size), .p1_unsigned(p1_unsigned), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_be(sram_be), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM: read data appears the cycle after the enable.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        for (int i = 0; i < 4; i++)
          if (sram_be[i]) mem[sram_addr[9:0]][8*i +: 8] <= sram_wdata[8*i +: 8];
      end else begin
        sram_rdata <= mem[sram_addr[9:0]];
      end
    end
  end

  // Drives one request from a drive point and records what the DUT did
  // over the accept cycle (T) and the two cycles after it.
  task automatic run_txn(input int p, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    logic got;
    got = 1'b0;
    o_wait = 0;
    if (p == 0) begin
      p0_valid = 1'b1; p0_write = wr; p0_size = sz; p0_unsigned = uns; p0_addr = addr; p0_wdata = wd;
    end else begin
      p1_valid = 1'b1; p1_write = wr; p1_size = sz; p1_unsigned = uns; p1_addr = addr; p1_wdata = wd;
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (((p == 0) ? p0_ready : p1_ready) === 1'b1) begin
        got = 1'b1;
        break;
      end
      o_wait++;
      @(posedge clk); #1;
    end
    o_ready = got;
    @(posedge clk); #1;
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    @(negedge clk);
    o_en1 = sram_en; o_we1 = sram_we; o_addr1 = sram_addr; o_be1 = sram_be; o_wd1 = sram_wdata;
    o_rv1  = (p == 0) ? p0_rsp_valid : p1_rsp_valid;
    o_rd1  = (p == 0) ? p0_rsp_rdata : p1_rsp_rdata;
    o_err1 = (p == 0) ? p0_rsp_err   : p1_rsp_err;
    o_orv1 = (p == 0) ? p1_rsp_valid : p0_rsp_valid;
    @(posedge clk); #1;
    @(negedge clk);
    o_en2  = sram_en;
    o_rv2  = (p == 0) ? p0_rsp_valid : p1_rsp_valid;
    o_rd2  = (p == 0) ? p0_rsp_rdata : p1_rsp_rdata;
    o_err2 = (p == 0) ? p0_rsp_err   : p1_rsp_err;
    o_orv2 = (p == 0) ? p1_rsp_valid : p0_rsp_valid;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++;
    if ({p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err, sram_en, sram_we} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b exp=00000000",
               {p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err, sram_en, sram_we});
    end
    n_tests++;
    if ({p0_rsp_rdata, p1_rsp_rdata, sram_wdata, sram_addr, sram_be} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got=%h %h %h %h %h exp=all zero",
               p0_rsp_rdata, p1_rsp_rdata, sram_wdata, sram_addr, sram_be);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_load_word();
    mem[10'h040] = 32'hDEADBEEF;
    run_txn(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    n_tests++;
    if (!(o_ready === 1'b1 && o_wait == 0)) begin
      n_fail++;
      $display("FAIL lw_ready got ready=%b wait=%0d exp ready=1 wait=0", o_ready, o_wait);
    end
    n_tests++;
    if ({o_en1, o_we1, o_addr1, o_be1} !== {1'b1, 1'b0, 30'h40, 4'hF}) begin
      n_fail++;
      $display("FAIL lw_issue got en=%b we=%b addr=%h be=%b exp en=1 we=0 addr=40 be=1111",
               o_en1, o_we1, o_addr1, o_be1);
    end
    n_tests++;
    if ({o_rv1, o_rv2, o_orv1, o_orv2, o_err2} !== 5'b01000) begin
      n_fail++;
      $display("FAIL lw_rsp_timing got=%b exp=01000", {o_rv1, o_rv2, o_orv1, o_orv2, o_err2});
    end
    n_tests++;
    if (o_rd2 !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL lw_rdata got=%h exp=deadbeef", o_rd2);
    end
  endtask

  task automatic test_byte_store_load();
    mem[10'h080] = 32'h0;
    run_txn(1, 1'b1, 2'b00, 1'b0, 32'h203, 32'h123456A5);
    n_tests++;
    if ({o_en1, o_we1, o_addr1, o_be1} !== {1'b1, 1'b1, 30'h80, 4'b1000}) begin
      n_fail++;
      $display("FAIL sb_issue got en=%b we=%b addr=%h be=%b exp en=1 we=1 addr=80 be=1000",
               o_en1, o_we1, o_addr1, o_be1);
    end
    n_tests++;
    if (o_wd1 !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL sb_wdata got=%h exp=a5a5a5a5", o_wd1);
    end
    n_tests++;
    if ({o_rv2, o_err2, o_orv2, o_rd2} !== {3'b100, 32'h0}) begin
      n_fail++;
      $display("FAIL sb_rsp got v=%b err=%b other=%b rd=%h exp v=1 err=0 other=0 rd=0",
               o_rv2, o_err2, o_orv2, o_rd2);
    end
    run_txn(1, 1'b0, 2'b00, 1'b0, 32'h203, 32'h0);
    n_tests++;
    if (o_rd2 !== 32'hFFFFFFA5) begin
      n_fail++;
      $display("FAIL lb_signed got=%h exp=ffffffa5", o_rd2);
    end
    run_txn(1, 1'b0, 2'b00, 1'b1, 32'h203, 32'h0);
    n_tests++;
    if (o_rd2 !== 32'h000000A5) begin
      n_fail++;
      $display("FAIL lbu got=%h exp=000000a5", o_rd2);
    end
  endtask

  task automatic test_half_and_errors();
    mem[10'h040] = 32'h88776655;
    run_txn(1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
    n_tests++;
    if ({o_be1, o_rd2} !== {4'b1100, 32'h00008877}) begin
      n_fail++;
      $display("FAIL lhu got be=%b rd=%h exp be=1100 rd=00008877", o_be1, o_rd2);
    end
    run_txn(0, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
    n_tests++;
    if (o_rd2 !== 32'hFFFF8877) begin
      n_fail++;
      $display("FAIL lh_signed got=%h exp=ffff8877", o_rd2);
    end
    run_txn(0, 1'b1, 2'b01, 1'b0, 32'h106, 32'h0000BEEF);
    n_tests++;
    if ({o_be1, o_wd1, o_addr1} !== {4'b1100, 32'hBEEFBEEF, 30'h41}) begin
      n_fail++;
      $display("FAIL sh_issue got be=%b wd=%h addr=%h exp be=1100 wd=beefbeef addr=41", o_be1, o_wd1, o_addr1);
    end
    run_txn(1, 1'b0, 2'b01, 1'b0, 32'h101, 32'h0);
    n_tests++;
    if ({o_rv1, o_err1, o_orv1, o_en1, o_en2, o_rv2} !== 6'b110000) begin
      n_fail++;
      $display("FAIL half_misalign got=%b exp=110000", {o_rv1, o_err1, o_orv1, o_en1, o_en2, o_rv2});
    end
    n_tests++;
    if (o_rd1 !== 32'h0) begin
      n_fail++;
      $display("FAIL err_rdata got=%h exp=00000000", o_rd1);
    end
    run_txn(0, 1'b0, 2'b10, 1'b0, 32'h102, 32'h0);
    n_tests++;
    if ({o_rv1, o_err1, o_en1, o_en2} !== 4'b1100) begin
      n_fail++;
      $display("FAIL word_misalign got=%b exp=1100", {o_rv1, o_err1, o_en1, o_en2});
    end
    run_txn(1, 1'b1, 2'b11, 1'b0, 32'h100, 32'h0);
    n_tests++;
    if ({o_rv1, o_err1, o_en1, o_en2} !== 4'b1100) begin
      n_fail++;
      $display("FAIL size_illegal got=%b exp=1100", {o_rv1, o_err1, o_en1, o_en2});
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp;
    logic [31:0] rd, idle_rd, exp_rd;
    int          ph, gp;
    mem[10'h004] = 32'h11111111;
    mem[10'h008] = 32'h22222222;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    p0_valid = 1'b1; p0_write = 1'b0; p0_size = 2'b10; p0_unsigned = 1'b0; p0_addr = 32'h10;
    p1_valid = 1'b1; p1_write = 1'b0; p1_size = 2'b10; p1_unsigned = 1'b0; p1_addr = 32'h20;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      ph  = c % 3;
      gp  = (c / 3) % 2;
      exp = {ph == 0 && gp == 0, ph == 0 && gp == 1, ph == 2 && gp == 0, ph == 2 && gp == 1};
      n_tests++;
      if ({p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid} !== exp) begin
        n_fail++;
        $display("FAIL rr_cycle%0d got=%b exp=%b", c, {p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid}, exp);
      end
      if (ph == 2) begin
        rd      = (gp == 0) ? p0_rsp_rdata : p1_rsp_rdata;
        idle_rd = (gp == 0) ? p1_rsp_rdata : p0_rsp_rdata;
        exp_rd  = (gp == 0) ? 32'h11111111 : 32'h22222222;
        n_tests++;
        if ({rd, idle_rd} !== {exp_rd, 32'h0}) begin
          n_fail++;
          $display("FAIL rr_data%0d got=%h idle=%h exp=%h idle=00000000", c, rd, idle_rd, exp_rd);
        end
      end
      @(posedge clk); #1;
    end
    p0_valid = 1'b0;
    p1_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    mem[10'h040] = 32'h88776655;
    p0_valid = 1'b1; p0_write = 1'b0; p0_size = 2'b10; p0_unsigned = 1'b0; p0_addr = 32'h100;
    @(negedge clk);
    n_tests++;
    if (p0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mr_accept got=%b exp=1", p0_ready);
    end
    @(posedge clk); #1;
    p0_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    n_tests++;
    if (sram_en !== 1'b1) begin
      n_fail++;
      $display("FAIL mr_issue got en=%b exp=1", sram_en);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if ({sram_en, p0_rsp_valid, p1_rsp_valid} !== 3'b000) begin
        n_fail++;
        $display("FAIL mr_abort%0d got=%b exp=000", c, {sram_en, p0_rsp_valid, p1_rsp_valid});
      end
      @(posedge clk); #1;
    end
    run_txn(1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    n_tests++;
    if (!(o_ready === 1'b1 && o_wait == 0 && o_rd2 === 32'h88776655)) begin
      n_fail++;
      $display("FAIL mr_after got ready=%b wait=%0d rd=%h exp ready=1 wait=0 rd=88776655",
               o_ready, o_wait, o_rd2);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0;
    p0_valid = 1'b0; p0_write = 1'b0; p0_size = 2'b00; p0_unsigned = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
    p1_valid = 1'b0; p1_write = 1'b0; p1_size = 2'b00; p1_unsigned = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
    sram_rdata = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    test_reset();
    test_load_word();
    test_byte_store_load();
    test_half_and_errors();
    test_round_robin();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
